// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the IF/LS memory arbiter.
//   op_size_t     - access size encoding presented to external_memory
//   arb_state_t   - arbiter FSM states
//   port_t        - requester identity recorded with each accepted request
//   is_misaligned - alignment / illegal-size check on the low address bits
package mem_arb_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'd0,
    SIZE_HALF    = 2'd1,
    SIZE_WORD    = 2'd2,
    SIZE_ILLEGAL = 2'd3
  } op_size_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_t;

  // Only the two low address bits can make an access misaligned, so only
  // those are passed in.
  function automatic logic is_misaligned(input op_size_t size, input logic [1:0] addr);
    case (size)
      SIZE_HALF:    return addr[0];
      SIZE_WORD:    return addr != 2'b00;
      SIZE_ILLEGAL: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: priority + starvation-override grant logic.
//   clk, reset_n   - clock, synchronous active-low reset
//   if_req, ls_req - raw requests from the two ports
//   accept_en      - high in cycles where the arbiter may accept a request
//   grant          - one-hot grant, bit 0 = IF, bit 1 = LS (combinational)
// stall_cnt counts consecutive contested losses of the non-preferred port.
// When it reaches MAX_STALL the non-preferred port wins the next contested
// cycle, which clears the count. Uncontested cycles leave it untouched.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int LS_PRIORITY = 1,
  parameter int MAX_STALL   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       if_req,
  input  logic       ls_req,
  input  logic       accept_en,
  output logic [1:0] grant
);

  localparam int CW = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;

  logic [CW-1:0] stall_cnt;
  logic          contested;
  logic          starved;
  logic          ls_wins;

  assign contested = if_req && ls_req;
  assign starved   = (stall_cnt == CW'(MAX_STALL));

  always_comb begin
    grant   = 2'b00;
    ls_wins = 1'b0;
    if (accept_en) begin
      if (contested) begin
        // Preferred port wins unless the other one has been starved.
        ls_wins = (LS_PRIORITY != 0) ? !starved : starved;
        grant   = ls_wins ? 2'b10 : 2'b01;
      end else begin
        grant = {ls_req, if_req};
      end
    end
  end

  // A contested cycle with the counter saturated is exactly the cycle the
  // non-preferred port wins, so that is where it clears.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (accept_en && contested) begin
      if (starved) stall_cnt <= '0;
      else         stall_cnt <= stall_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external_memory between instruction fetch (IF)
// and load/store (LS). One request in flight; one memory cycle per access.
//   clk, reset_n          - clock, synchronous active-low reset
//   if_req/if_addr        - IF request (word reads only), held until if_ack
//   if_ack, if_rsp_*      - IF accept pulse and registered response
//   ls_req/ls_write/ls_size/ls_addr/ls_wdata - LS request, held until ls_ack
//   ls_ack, ls_rsp_*      - LS accept pulse and registered response
//   mem_*                 - external_memory port
// Handshake: a request is accepted in the cycle where req and the matching
// ack are both high (ack is combinational, IDLE/RESPOND only); a request
// dropped before its ack is simply withdrawn. Each *_rsp_valid is a single
// cycle strobe and the response fields hold until the next response.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LS_PRIORITY = 1,
  parameter int MAX_STALL   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_fault,
  input  logic        ls_req,
  input  logic        ls_write,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_ack,
  output logic        ls_rsp_valid,
  output logic [31:0] ls_rsp_data,
  output logic        ls_rsp_fault,
  output logic        ls_rsp_misaligned,
  output logic        mem_enable,
  output logic        mem_is_write,
  output logic [1:0]  mem_op_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_in,
  input  logic [31:0] mem_out,
  input  logic        mem_access_fault
);

  arb_state_t  state;
  port_t       req_port;
  logic        req_write;
  op_size_t    req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        accept_en;
  logic [1:0]  grant;

  port_t       acc_port;
  logic        acc_write;
  op_size_t    acc_size;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_misaligned;

  assign accept_en = (state != ST_ACCESS);

  mem_arb_grant #(
    .LS_PRIORITY (LS_PRIORITY),
    .MAX_STALL   (MAX_STALL)
  ) u_grant (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .ls_req    (ls_req),
    .accept_en (accept_en),
    .grant     (grant)
  );

  assign if_ack = grant[0];
  assign ls_ack = grant[1];

  // Fields of whichever request is being accepted this cycle. IF is
  // always a word read with no store data.
  always_comb begin
    acc_port  = PORT_IF;
    acc_write = 1'b0;
    acc_size  = SIZE_WORD;
    acc_addr  = if_addr;
    acc_wdata = '0;
    if (grant[1]) begin
      acc_port  = PORT_LS;
      acc_write = ls_write;
      acc_size  = op_size_t'(ls_size);
      acc_addr  = ls_addr;
      acc_wdata = ls_wdata;
    end
    acc_misaligned = is_misaligned(acc_size, acc_addr[1:0]);
  end

  assign mem_enable   = (state == ST_ACCESS);
  assign mem_is_write = req_write;
  assign mem_op_size  = req_size;
  assign mem_addr     = req_addr;
  assign mem_in       = req_wdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      req_port          <= PORT_IF;
      req_write         <= 1'b0;
      req_size          <= SIZE_BYTE;
      req_addr          <= '0;
      req_wdata         <= '0;
      if_rsp_valid      <= 1'b0;
      if_rsp_data       <= '0;
      if_rsp_fault      <= 1'b0;
      ls_rsp_valid      <= 1'b0;
      ls_rsp_data       <= '0;
      ls_rsp_fault      <= 1'b0;
      ls_rsp_misaligned <= 1'b0;
    end else begin
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      case (state)
        ST_ACCESS: begin
          state <= ST_RESPOND;
          if (req_port == PORT_LS) begin
            ls_rsp_valid      <= 1'b1;
            ls_rsp_data       <= req_write ? 32'd0 : mem_out;
            ls_rsp_fault      <= mem_access_fault;
            ls_rsp_misaligned <= 1'b0;
          end else begin
            if_rsp_valid <= 1'b1;
            if_rsp_data  <= mem_out;
            if_rsp_fault <= mem_access_fault;
          end
        end
        default: begin
          if (grant != 2'b00) begin
            req_port  <= acc_port;
            req_write <= acc_write;
            req_size  <= acc_size;
            req_addr  <= acc_addr;
            req_wdata <= acc_wdata;
            if (acc_misaligned) begin
              // Rejected locally: answer next cycle, never touch memory.
              state <= ST_RESPOND;
              if (acc_port == PORT_LS) begin
                ls_rsp_valid      <= 1'b1;
                ls_rsp_data       <= '0;
                ls_rsp_fault      <= 1'b0;
                ls_rsp_misaligned <= 1'b1;
              end else begin
                if_rsp_valid <= 1'b1;
                if_rsp_data  <= '0;
                if_rsp_fault <= 1'b1;
              end
            end else begin
              state <= ST_ACCESS;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single `external_memory` instance between instruction fetch (IF) and load/store (LS). It accepts one request at a time and drives the memory port for exactly one cycle per access. It returns a registered response to the winning requester. Misaligned LS accesses are rejected locally and never reach memory.

## Interface
Parameters:
- `LS_PRIORITY`, default 1: 1 means LS wins contested cycles; 0 means IF wins.
- `MAX_STALL`, default 4: number of consecutive contested losses after which the losing port is forced to win.

Ports:
- `clk`, in, 1: the single clock.
- `reset_n`, in, 1: reset, synchronous and active-low.
- `if_req`, in, 1: IF request. It is held, with `if_addr`, until `if_ack`.
- `if_addr`, in, 32: fetch address. Fetches are always word size and read-only.
- `if_ack`, out, 1: one-cycle pulse when the IF request is accepted.
- `if_rsp_valid`, out, 1: one-cycle IF response strobe.
- `if_rsp_data`, out, 32: fetched word.
- `if_rsp_fault`, out, 1: access fault or misaligned fetch.
- `ls_req`, in, 1: LS request. It is held, with all `ls_*` fields, until `ls_ack`.
- `ls_write`, in, 1: 1 means store.
- `ls_size`, in, 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `ls_addr`, in, 32: LS address.
- `ls_wdata`, in, 32: store data, passed to memory unmodified.
- `ls_ack`, out, 1: one-cycle pulse when the LS request is accepted.
- `ls_rsp_valid`, out, 1: one-cycle LS response strobe.
- `ls_rsp_data`, out, 32: raw memory read value, with no extension. It is 0 for stores and for rejected accesses.
- `ls_rsp_fault`, out, 1: memory access fault.
- `ls_rsp_misaligned`, out, 1: alignment or illegal-size reject.
- `mem_enable`, out, 1: connects to `external_memory.enable`.
- `mem_is_write`, out, 1: connects to `external_memory.is_write`.
- `mem_op_size`, out, 2: connects to `external_memory.op_size`.
- `mem_addr`, out, 32: connects to `external_memory.addr`.
- `mem_in`, out, 32: connects to `external_memory.in`.
- `mem_out`, in, 32: connects to `external_memory.out`.
- `mem_access_fault`, in, 1: connects to `external_memory.access_fault`.

## Operation
**States:** IDLE, ACCESS, RESPOND.

**Acceptance:**
- A request is accepted in IDLE or RESPOND.
- On acceptance, the matching `*_ack` is asserted combinationally in the accept cycle and the request is latched into the `req_*` registers.

**Alignment check:**
- The request is misaligned if:
  - size is half and `addr[0]` = 1;
  - size is word and `addr[1:0]` ≠ 0;
  - size is 3.
- IF is always checked as word size.

**Transitions:**
- Aligned accept goes to ACCESS.
- Misaligned accept goes to RESPOND with:
  - misaligned set, or `if_rsp_fault` set for IF;
  - data = 0;
  - `mem_enable` never asserted.
- ACCESS always goes to RESPOND. At the clock edge, `mem_out` and `mem_access_fault` are captured into the response registers.
- RESPOND goes to ACCESS or RESPOND if a new request is accepted in the same cycle; otherwise it goes to IDLE.

**Memory-port drive:**
- `mem_enable` = 1 only in ACCESS.
- `mem_is_write`, `mem_op_size`, `mem_addr` and `mem_in` are always driven from the `req_*` registers.

**Response:**
- The response strobe goes only to the port recorded in `req_port`.
- Store responses carry the fault flag only.

**Arbitration** (only IDLE and RESPOND sample requests):
- With one requester, that requester wins.
- With both requesting, the preferred port (set by `LS_PRIORITY`) wins, unless the other port's `stall_cnt` equals `MAX_STALL`.
- `stall_cnt` increments on each contested loss of the non-preferred port. It saturates at `MAX_STALL` and clears when that port wins.
- Uncontested cycles do not change `stall_cnt`.

**Reset:** while `reset_n` = 0 at a clock edge:
- state goes to IDLE;
- all `req_*` registers, response registers and `stall_cnt` go to 0;
- any in-flight access or response is dropped, with no strobe.

## Timing
**Reset values:** all outputs are 0 (`*_ack`, `*_rsp_*`, and all `mem_*`).

**Aligned access** (accept at cycle N):
- `mem_enable` high in cycle N+1 only;
- `*_rsp_valid` high in cycle N+2 only, with data and fault stable that cycle.
- Back-to-back accepts in RESPOND give one access per 2 cycles.

**Misaligned reject** (accept at cycle N): `*_rsp_valid` high in N+1. There is no memory cycle.

**Acknowledge:**
- `*_ack` is combinational from state, requests and `stall_cnt`.
- At most one `*_ack` is high per cycle.
- There is no ack in ACCESS.

**Response outputs:**
- `*_rsp_data` and the fault/misaligned flags are registered and hold until the next response.
- They are valid only with `*_rsp_valid`.

**Request protocol:** deasserting a request before its ack is allowed. It simply withdraws the request.

## Structure
- Package `mem_arb_pkg` holds:
  - `op_size_t` (`SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`, `SIZE_ILLEGAL`);
  - `arb_state_t`;
  - `port_t` (`PORT_IF`, `PORT_LS`);
  - the function `is_misaligned(size, addr)`.
- Sub-module `mem_arb_grant` holds the priority and starvation logic:
  - inputs: both requests and an accept-enable;
  - outputs: grant one-hot;
  - contains `stall_cnt`.
- The top level holds the FSM, the request/response registers and the memory-port drive.

## Test plan
- **Single LS load:** LS load word at 0x100 at cycle N with memory returning 0xDEADBEEF → `ls_ack` at N, `mem_enable` at N+1 with `mem_addr` = 0x100 and `mem_op_size` = 2, `ls_rsp_valid` at N+2 with data 0xDEADBEEF.
- **Contention with starvation override:** IF and LS request continuously with `LS_PRIORITY` = 1 and `MAX_STALL` = 4 → grant order LS ×4, IF, LS ×4, IF; `stall_cnt` never exceeds 4.
- **Misaligned rejects:** LS half at 0x101 → `ls_rsp_misaligned` = 1 one cycle after ack, `mem_enable` stays 0. Size 3 at 0x0 gives the same result.
- **Faulting store:** LS store at 0x8000_0000 with `mem_access_fault` = 1 → `ls_rsp_fault` = 1 at N+2, `mem_is_write` = 1 and `mem_in` = `ls_wdata` during N+1.
- **Reset mid-access:** `reset_n` low during ACCESS → next cycle state is IDLE, no `*_rsp_valid`, all outputs 0. After release, a fresh IF request is accepted in the first cycle.
- **Back-to-back IF fetches** at 0x0 and 0x4 (second request held during RESPOND) → acks at N and N+2, `mem_enable` at N+1 and N+3, responses at N+2 and N+4.
